// File: rtl/awg_dds.sv
// awg_dds: sample-table DDS player with pass-through, continuous and burst modes.
// Optional linear interpolation between adjacent entries is enabled by defining AWG_INTERP_EN.
module awg_dds #(
    parameter int NBITS  = 12,
    parameter int PTBITS = 10,
    parameter int FBITS  = 14
) (
    input  logic                    ck,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [PTBITS-1:0]       wr_addr,
    input  logic [NBITS-1:0]        wr_data,
    input  logic [1:0]              mode,
    input  logic                    start,
    input  logic                    stop,
    input  logic [PTBITS+FBITS-1:0] step,
    input  logic [PTBITS-1:0]       len,
    input  logic [9:0]              pre,
    input  logic [15:0]             ncyc,
    output logic [NBITS-1:0]        out,
    output logic                    busy,
    output logic                    sync
);

    localparam int ACCBITS = PTBITS + FBITS;
    localparam int DEPTH   = 1 << PTBITS;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           mode_q, mode_d;
    logic [ACCBITS-1:0]   step_q, step_d;
    logic [PTBITS-1:0]    len_q, len_d;
    logic [9:0]           pre_q, pre_d;
    logic [15:0]          ncyc_q, ncyc_d;
    logic [ACCBITS-1:0]   acc_q, acc_d;
    logic [9:0]           pcnt_q, pcnt_d;
    logic [15:0]          cyc_q, cyc_d;
    logic                 psync_q, psync_d;

    logic [NBITS-1:0]     tbl_q [DEPTH];

    logic                 start_ok;
    logic                 tick;
    logic                 wrap;
    logic                 burst_done;
    logic                 flush;
    logic [PTBITS:0]      nent;
    logic [ACCBITS:0]     span;
    logic [ACCBITS:0]     sum;
    logic [ACCBITS-1:0]   acc_wr;
    logic [PTBITS-1:0]    idx;

    logic                 rd_vld_d, rd_vld_q, rd_sync_q;
    logic [NBITS-1:0]     s0_q;

    logic                 pipe_vld, pipe_sync;
    logic [NBITS-1:0]     pipe_dat;

    logic [NBITS-1:0]     out_q, out_d;
    logic                 sync_q, sync_d;

    // Table has no reset so contents survive a reset of the control path.
    always_ff @(posedge ck) begin
        if (wr_en) begin
            tbl_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        start_ok   = start && ((mode == 2'b01) || ((mode == 2'b10) && (ncyc != 16'd0)));
        tick       = (pcnt_q == pre_q);
        nent       = {1'b0, len_q} + {{PTBITS{1'b0}}, 1'b1};
        span       = {nent, {FBITS{1'b0}}};
        sum        = {1'b0, acc_q} + {1'b0, step_q};
        wrap       = (sum >= span);
        acc_wr     = sum[ACCBITS-1:0] - span[ACCBITS-1:0];
        burst_done = (mode_q == 2'b10) && ((cyc_q + 16'd1) == ncyc_q);
        flush      = (state_q == RUN) && stop;
        idx        = acc_q[ACCBITS-1:FBITS];
        rd_vld_d   = (state_q == RUN) && !stop;
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        step_d  = step_q;
        len_d   = len_q;
        pre_d   = pre_q;
        ncyc_d  = ncyc_q;
        acc_d   = acc_q;
        pcnt_d  = pcnt_q;
        cyc_d   = cyc_q;
        psync_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_ok) begin
                    state_d = RUN;
                    mode_d  = mode;
                    step_d  = step;
                    len_d   = len;
                    pre_d   = pre;
                    ncyc_d  = ncyc;
                    acc_d   = '0;
                    pcnt_d  = '0;
                    cyc_d   = '0;
                    psync_d = 1'b1;
                end
            end
            RUN: begin
                if (stop) begin
                    state_d = IDLE;
                end else if (tick) begin
                    pcnt_d = '0;
                    acc_d  = wrap ? acc_wr : sum[ACCBITS-1:0];
                    if (wrap) begin
                        psync_d = 1'b1;
                        cyc_d   = cyc_q + 16'd1;
                        // Burst ends on the period boundary; samples already in the pipe still drain.
                        if (burst_done) begin
                            state_d = IDLE;
                        end
                    end
                end else begin
                    pcnt_d = pcnt_q + 10'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mode_q  <= '0;
            step_q  <= '0;
            len_q   <= '0;
            pre_q   <= '0;
            ncyc_q  <= '0;
            acc_q   <= '0;
            pcnt_q  <= '0;
            cyc_q   <= '0;
            psync_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            len_q   <= len_d;
            pre_q   <= pre_d;
            ncyc_q  <= ncyc_d;
            acc_q   <= acc_d;
            pcnt_q  <= pcnt_d;
            cyc_q   <= cyc_d;
            psync_q <= psync_d;
        end
    end

`ifdef AWG_INTERP_EN
    localparam int XW = NBITS + 9;

    logic [NBITS-1:0]     s1_q;
    logic [7:0]           frac_q;
    logic [PTBITS-1:0]    nidx;
    logic                 mid_vld_q, mid_sync_q;
    logic [NBITS-1:0]     mid_dat_q, mid_dat_d;
    logic signed [XW-1:0] s0_x, s1_x, f_x, prod;

    always_comb begin
        nidx      = (idx == len_q) ? '0 : idx + {{(PTBITS-1){1'b0}}, 1'b1};
        s0_x      = {{9{s0_q[NBITS-1]}}, s0_q};
        s1_x      = {{9{s1_q[NBITS-1]}}, s1_q};
        f_x       = {{(NBITS+1){1'b0}}, frac_q};
        prod      = (s1_x - s0_x) * f_x;
        mid_dat_d = NBITS'(s0_x + (prod >>> 8));
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q   <= 1'b0;
            rd_sync_q  <= 1'b0;
            s0_q       <= '0;
            s1_q       <= '0;
            frac_q     <= '0;
            mid_vld_q  <= 1'b0;
            mid_sync_q <= 1'b0;
            mid_dat_q  <= '0;
        end else begin
            rd_vld_q   <= rd_vld_d;
            rd_sync_q  <= rd_vld_d && psync_q;
            if (rd_vld_d) begin
                s0_q   <= tbl_q[idx];
                s1_q   <= tbl_q[nidx];
                frac_q <= acc_q[FBITS-1:FBITS-8];
            end
            mid_vld_q  <= rd_vld_q && !flush;
            mid_sync_q <= rd_sync_q && !flush;
            if (rd_vld_q) begin
                mid_dat_q <= mid_dat_d;
            end
        end
    end

    always_comb begin
        pipe_vld  = mid_vld_q;
        pipe_sync = mid_sync_q;
        pipe_dat  = mid_dat_q;
    end
`else
    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld_q  <= 1'b0;
            rd_sync_q <= 1'b0;
            s0_q      <= '0;
        end else begin
            rd_vld_q  <= rd_vld_d;
            rd_sync_q <= rd_vld_d && psync_q;
            if (rd_vld_d) begin
                s0_q <= tbl_q[idx];
            end
        end
    end

    always_comb begin
        pipe_vld  = rd_vld_q;
        pipe_sync = rd_sync_q;
        pipe_dat  = s0_q;
    end
`endif

    always_comb begin
        out_d  = out_q;
        sync_d = 1'b0;
        if (flush) begin
            out_d = out_q;
        end else if (pipe_vld) begin
            out_d  = pipe_dat;
            sync_d = pipe_sync;
        end else if ((state_q == IDLE) && ((mode == 2'b00) || (mode == 2'b11))) begin
            out_d = wr_data;
        end
    end

    always_ff @(posedge ck or negedge rst_n) begin
        if (!rst_n) begin
            out_q  <= '0;
            sync_q <= 1'b0;
        end else begin
            out_q  <= out_d;
            sync_q <= sync_d;
        end
    end

    assign out  = out_q;
    assign sync = sync_q;
    assign busy = (state_q == RUN);

endmodule

// File: doc/awg_dds.md
# awg_dds

Parametrised successor to the single-channel arbitrary waveform generator: a sample table is played back through a fractional phase accumulator, so output frequency is set by a step value rather than by table contents. Adds programmable table length, continuous and burst modes, start/stop control, a busy flag and a period sync pulse. Sits between the host register interface, which loads the table and controls, and the DAC data path.

## Interface
- NBITS, 12, sample width.
- PTBITS, 10, table address width; depth 2**PTBITS.
- FBITS, 14, fractional phase bits; accumulator width ACCBITS = PTBITS+FBITS.
- ck  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- wr_en  in  1  table write strobe.
- wr_addr  in  PTBITS  table write address.
- wr_data  in  NBITS  table write data; also the pass-through sample.
- mode  in  2  00 pass-through, 01 continuous, 10 burst, 11 reserved (treated as 00).
- start  in  1  single-cycle start pulse.
- stop  in  1  single-cycle stop pulse.
- step  in  ACCBITS  phase increment, {integer, fraction}.
- len  in  PTBITS  last table index played; period = len+1 entries.
- pre  in  10  prescaler; accumulator advances every pre+1 cycles.
- ncyc  in  16  burst period count.
- out  out  NBITS  output sample, registered.
- busy  out  1  high in RUN.
- sync  out  1  one-cycle pulse aligned with the first sample of every period at out.

## Operation
- States: IDLE, RUN. Reset state IDLE.
- IDLE: mode 00/11 -> out <= wr_data each cycle. Mode 01/10 -> out holds its value.
- IDLE -> RUN on start with mode 01, or mode 10 and ncyc != 0. On entry: mode, step, len, pre, ncyc latched; acc, prescaler count and period count cleared to 0. Start with mode 10 and ncyc == 0 is ignored.
- RUN: tick asserts when prescaler count == pre_latched, after which the count is cleared; otherwise the count increments. pre = 0 -> tick every cycle.
- On tick: sum = acc + step, computed at ACCBITS+1 bits. If sum >= (len+1)<<FBITS, acc <= sum - ((len+1)<<FBITS) and a wrap is flagged; otherwise acc <= sum.
- Constraint on step: step < (len+1)<<FBITS. Step values outside this range are illegal; behaviour is undefined and the bench does not drive them.
- Read address = acc[ACCBITS-1:FBITS].
- Burst: the period count increments on each wrap. The wrap that makes it equal ncyc returns the block to IDLE; the sample at index 0 of the next period is not emitted.
- stop in RUN -> IDLE on the next edge. start in RUN is ignored. stop in IDLE is ignored. start and stop in the same IDLE cycle -> start wins. start and stop in the same RUN cycle -> stop wins.
- Leaving RUN: out holds the last emitted sample; in-flight pipeline samples are discarded.
- Table writes are accepted in any state. A read of the same address in the same cycle returns the old data. Table contents are not cleared by reset.

## Timing
- Reset values: out = 0, busy = 0, sync = 0, acc = 0, state = IDLE.
- Reset is asynchronous: asserting rst_n mid-RUN clears all outputs immediately.
- Pass-through latency: wr_data to out is 1 cycle.
- Playback latency: accumulator value to out is 2 cycles (table read register, output register). Data for index 0 first appears at out 2 cycles after the start edge.
- busy rises on the edge that samples start and falls on the edge that enters IDLE.
- sync is delayed through the pipeline so it coincides with index 0 at out, including the first sample after start.

## Configuration
- AWG_INTERP_EN defined: linear interpolation.
  - out = s0 + (((s1 - s0) * f) >>> 8), with f = acc[FBITS-1:FBITS-8]; s1 is the entry at index (idx == len ? 0 : idx+1).
  - Arithmetic is signed at NBITS+9 bits, truncated to NBITS.
  - Adds 1 cycle of playback latency (3 total); sync latency tracks it.
- AWG_INTERP_EN undefined: nearest lower sample, no multiplier, 2-cycle latency.

## Test plan
- Reset during RUN -> out, busy and sync are 0 without waiting for a clock edge; table data is retained.
- mode 00, wr_data = 0x5A5 -> out = 0x5A5 one cycle later, busy = 0.
- Table[i] = i; len = 3, step = 1<<FBITS, pre = 0, mode 01, start -> out 0,1,2,3,0,… from cycle 2; sync high whenever out = 0.
- pre = 2, otherwise as above -> each value is held for 3 cycles.
- mode 10, ncyc = 2, len = 3 -> exactly 8 samples; busy falls after the second wrap; out holds 3.
- step = 0x2000 (0.5 entry per tick, FBITS = 14), table[0] = 0, table[1] = 100 -> without the macro: 0,0,100,100; with AWG_INTERP_EN: 0,50,100,….
